// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem handshake, stall hold buffer and redirect squash.
// Optional FETCH_HALT_DETECT_EN adds HALT opcode detection and the HALTED state.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0FFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] Instruction_out,
  output logic [15:0] PC_plus_two_out,
  output logic        fetch_valid,
  output logic        halted
);

`ifdef FETCH_HALT_DETECT_EN
  typedef enum logic [1:0] {FETCH, SQUASH, HOLD, HALTED} state_t;

  function automatic logic is_halt(input logic [15:0] w);
    return w[15:11] == 5'b00000;
  endfunction
`else
  typedef enum logic [1:0] {FETCH, SQUASH, HOLD} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [15:0] buf_q, buf_d;

  logic        req_c, valid_c, halted_c;
  logic [15:0] instr_c, ppt_c, tgt;

  assign tgt = redirect_pc & 16'hFFFE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= 16'h0000;
      buf_q      <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      buf_q      <= buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    buf_d      = buf_q;
    req_c      = 1'b0;
    imem_addr  = pc_q;
    valid_c    = 1'b0;
    instr_c    = NOP_INSTR;
    ppt_c      = pc_q + 16'd2;
    halted_c   = 1'b0;
    case (state_q)
      FETCH: begin
        req_c = 1'b1;
        if (redirect) begin
          pc_d = tgt;
          // Keep the pending address alive until memory answers it.
          if (!imem_ready) begin
            req_addr_d = pc_q;
            state_d    = SQUASH;
          end
        end else if (imem_ready) begin
          valid_c = 1'b1;
          instr_c = imem_rdata;
          pc_d    = pc_q + 16'd2;
          if (stall) begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end
`ifdef FETCH_HALT_DETECT_EN
          else if (is_halt(imem_rdata)) state_d = HALTED;
`endif
        end
      end
      SQUASH: begin
        req_c     = 1'b1;
        imem_addr = req_addr_q;
        if (redirect) pc_d = tgt;
        if (imem_ready) state_d = FETCH;
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = tgt;
          buf_d   = NOP_INSTR;
          state_d = FETCH;
        end else begin
          // pc already advanced on capture, so pc is the held word's PC+2.
          valid_c = 1'b1;
          instr_c = buf_q;
          ppt_c   = pc_q;
          if (!stall) begin
            state_d = FETCH;
`ifdef FETCH_HALT_DETECT_EN
            if (is_halt(buf_q)) state_d = HALTED;
`endif
          end
        end
      end
`ifdef FETCH_HALT_DETECT_EN
      HALTED: begin
        halted_c = 1'b1;
        if (redirect) begin
          pc_d    = tgt;
          state_d = FETCH;
        end
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  // Outputs are forced to their idle values for as long as reset is held.
  assign imem_req        = rst & req_c;
  assign fetch_valid     = rst & valid_c;
  assign halted          = rst & halted_c;
  assign Instruction_out = fetch_valid ? instr_c : NOP_INSTR;
  assign PC_plus_two_out = fetch_valid ? ppt_c : pc_q + 16'd2;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized stall/redirect/latency
// against a transaction-level reference model and a variable-latency memory.
module tb_fetch_stage;
  localparam logic [15:0] NOP = 16'h0FFF;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_ready;
  logic [15:0] redirect_pc, imem_rdata;
  logic        imem_req, fetch_valid, halted;
  logic [15:0] imem_addr, Instruction_out, PC_plus_two_out;

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .Instruction_out(Instruction_out), .PC_plus_two_out(PC_plus_two_out),
    .fetch_valid(fetch_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // memory: word array plus one outstanding transaction with a wait count
  logic [15:0] mem [0:32767];
  bit txn;
  int wleft, wfix;

  // reference model: where fetch is, what is parked, what is pending
  logic [15:0] m_pc, m_old, m_held;
  bit          m_pend, m_has_held, m_stopped;

  task automatic model_reset();
    m_pc = 16'h0000; m_old = 16'h0000; m_held = NOP;
    m_pend = 0; m_has_held = 0; m_stopped = 0;
    txn = 0; wleft = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_req",   {15'd0, imem_req}, 16'd0);
    chk("rst_valid", {15'd0, fetch_valid}, 16'd0);
    chk("rst_halt",  {15'd0, halted}, 16'd0);
    chk("rst_instr", Instruction_out, NOP);
    chk("rst_ppt",   PC_plus_two_out, 16'h0002);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic cycle(input logic st, input logic rd, input logic [15:0] rpc);
    logic        e_req, e_v, e_h;
    logic [15:0] e_addr, e_ins, e_ppt, tgt;
    stall = st; redirect = rd; redirect_pc = rpc;
    if (imem_req && !txn) begin
      txn = 1;
      wleft = (wfix >= 0) ? wfix : ($urandom_range(0, 1) ? 0 : int'($urandom_range(1, 3)));
    end
    imem_ready = txn && (wleft == 0);
    imem_rdata = imem_ready ? mem[imem_addr[15:1]] : 16'($urandom);
    #1;
    tgt    = rpc & 16'hFFFE;
    e_req  = !m_has_held && !m_stopped;
    e_addr = m_pend ? m_old : m_pc;
    e_v = 0; e_ins = NOP; e_ppt = m_pc + 16'd2; e_h = m_stopped;
    if (m_stopped) begin
      if (rd) begin m_pc = tgt; m_stopped = 0; end
    end else if (m_has_held) begin
      if (rd) begin
        m_pc = tgt; m_has_held = 0;
      end else begin
        e_v = 1; e_ins = m_held; e_ppt = m_pc;
        if (!st) begin
          m_has_held = 0;
`ifdef FETCH_HALT_DETECT_EN
          if (m_held[15:11] == 5'd0) m_stopped = 1;
`endif
        end
      end
    end else if (m_pend) begin
      if (rd) m_pc = tgt;
      if (imem_ready) m_pend = 0;
    end else begin
      if (rd) begin
        if (!imem_ready) begin m_pend = 1; m_old = m_pc; end
        m_pc = tgt;
      end else if (imem_ready) begin
        e_v = 1; e_ins = imem_rdata; e_ppt = m_pc + 16'd2;
        m_pc = m_pc + 16'd2;
        if (st) begin m_has_held = 1; m_held = imem_rdata; end
`ifdef FETCH_HALT_DETECT_EN
        else if (imem_rdata[15:11] == 5'd0) m_stopped = 1;
`endif
      end
    end
    chk("req", {15'd0, imem_req}, {15'd0, e_req});
    if (e_req) chk("addr", imem_addr, e_addr);
    chk("valid", {15'd0, fetch_valid}, {15'd0, e_v});
    chk("instr", Instruction_out, e_ins);
    chk("ppt", PC_plus_two_out, e_ppt);
    chk("halted", {15'd0, halted}, {15'd0, e_h});
    @(posedge clk);
    if (imem_ready) txn = 0;
    else if (txn && wleft > 0) wleft--;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; stall = 0; redirect = 0; redirect_pc = 0;
    imem_ready = 0; imem_rdata = 0; wfix = 0;
    for (int i = 0; i < 32768; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 15) == 0) w[15:11] = 5'd0;
      else if (w[15:11] == 5'd0) w[15] = 1'b1;
      mem[i] = w;
    end
    mem[0] = 16'hC001; mem[1] = 16'hC002; mem[2] = 16'hC003; mem[3] = 16'hC004;
    mem[4] = 16'h0123; mem[8] = 16'hC010; mem[16'h20] = 16'hC040; mem[16'h7FFF] = 16'hCFFE;

    // zero-wait streaming
    do_reset();
    wfix = 0;
    repeat (3) cycle(0, 0, 0);
    // 3 wait cycles at 0, then stall as 0xC002 arrives, then resume at 4
    do_reset();
    wfix = 3;
    repeat (4) cycle(0, 0, 0);
    wfix = 0;
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    // redirect to 0x40 while waiting on addr 6
    wfix = 2;
    cycle(0, 1, 16'h0040);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    wfix = 0;
    cycle(0, 0, 0);
    // HALT at 8, then redirect to 0x10
    cycle(0, 1, 16'h0008);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 16'h0010);
    cycle(0, 0, 0);
    // wrap: 0xFFFE -> 0x0000 (bit 0 of target ignored)
    cycle(0, 1, 16'hFFFF);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    // reset in the middle of a wait
    wfix = 3;
    cycle(0, 0, 0);
    do_reset();
    wfix = 0;
    cycle(0, 0, 0);

    // randomized traffic
    wfix = -1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
